// File: rtl/instr_reg_reader.sv
// rtl/instr_reg_reader.sv - read-side sequencer for the 32-entry instruction register
// Walks read_pointer in INC/DEC/RAND order and streams each word over valid/ready.
module instr_reg_reader #(
   parameter int NUM_ENTRIES = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          order,
   input  logic [4:0]          first_addr,
   input  logic [5:0]          count,
   output logic [4:0]          read_pointer,
   input  logic [131:0]        instruction_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_opc,
   output logic signed [31:0]  out_op_a,
   output logic signed [31:0]  out_op_b,
   output logic signed [63:0]  out_result,
   output logic [4:0]          out_addr,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FINISH} state_t;
   typedef enum logic [1:0] {MODE_INC, MODE_RAND, MODE_DEC} mode_t;

   localparam logic [5:0] MAX_COUNT = 6'(NUM_ENTRIES);

   state_t     state;
   state_t     next_state;
   mode_t      mode;
   mode_t      start_mode;
   logic [5:0] remaining;
   logic [5:0] start_count;
   logic       handshake;

   // 5*a+3 is a full-period LCG mod 32, so RAND visits every entry once per 32 reads
   function automatic logic [4:0] next_addr(input logic [4:0] a, input mode_t m);
      logic [4:0] r;
      case (m)
         MODE_DEC:  r = a - 5'd1;
         MODE_RAND: r = (a << 2) + a + 5'd3;
         default:   r = a + 5'd1;
      endcase
      return r;
   endfunction

   assign handshake   = out_valid && out_ready;
   assign start_count = (count > MAX_COUNT) ? MAX_COUNT : count;

   always_comb begin
      case (order)
         4'd1:    start_mode = MODE_RAND;
         4'd2:    start_mode = MODE_DEC;
         default: start_mode = MODE_INC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (start_count == 6'd0) ? FINISH : FETCH;
            end
         end
         FETCH: next_state = HOLD;
         HOLD: begin
            if (handshake) begin
               next_state = (remaining == 6'd1) ? FINISH : FETCH;
            end
         end
         FINISH: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode         <= MODE_INC;
         remaining    <= 6'd0;
         read_pointer <= 5'd0;
         out_valid    <= 1'b0;
         out_opc      <= 4'd0;
         out_op_a     <= 32'sd0;
         out_op_b     <= 32'sd0;
         out_result   <= 64'sd0;
         out_addr     <= 5'd0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode         <= start_mode;
                  remaining    <= start_count;
                  read_pointer <= first_addr;
               end
            end
            FETCH: begin
               out_opc    <= instruction_word[131:128];
               out_op_a   <= instruction_word[127:96];
               out_op_b   <= instruction_word[95:64];
               out_result <= instruction_word[63:0];
               out_addr   <= read_pointer;
               out_valid  <= 1'b1;
            end
            HOLD: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  remaining <= remaining - 6'd1;
                  if (remaining != 6'd1) begin
                     read_pointer <= next_addr(read_pointer, mode);
                  end
               end
            end
            FINISH: done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_reg_reader.sv
// tb/tb_instr_reg_reader.sv - directed self-checking bench for instr_reg_reader
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_reg_reader;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [3:0]         order;
   logic [4:0]         first_addr;
   logic [5:0]         count;
   logic [4:0]         read_pointer;
   logic [131:0]       instruction_word;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_opc;
   logic signed [31:0] out_op_a;
   logic signed [31:0] out_op_b;
   logic signed [63:0] out_result;
   logic [4:0]         out_addr;
   logic               busy;
   logic               done;

   logic [131:0] mem [32];
   int tests = 0;
   int fails = 0;

   instr_reg_reader dut (
      .clk(clk), .reset(reset), .start(start), .order(order),
      .first_addr(first_addr), .count(count), .read_pointer(read_pointer),
      .instruction_word(instruction_word), .out_valid(out_valid),
      .out_ready(out_ready), .out_opc(out_opc), .out_op_a(out_op_a),
      .out_op_b(out_op_b), .out_result(out_result), .out_addr(out_addr),
      .busy(busy), .done(done)
   );

   assign instruction_word = mem[read_pointer];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [3:0] o, input logic [4:0] f, input logic [5:0] c);
      order = o; first_addr = f; count = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for a word, checks address and payload, then lets the handshake edge pass
   task automatic expect_word(input string tag, input logic [4:0] a);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 132'(out_valid), 132'd1);
      chk({tag, "_addr"}, 132'(out_addr), 132'(a));
      chk({tag, "_data"}, {out_opc, out_op_a, out_op_b, out_result}, mem[a]);
      @(negedge clk);
   endtask

   task automatic expect_done(input string tag);
      chk({tag, "_done_early"}, 132'(done), 132'd0);
      @(negedge clk);
      chk({tag, "_done"}, 132'(done), 132'd1);
      chk({tag, "_busy_after"}, 132'(busy), 132'd0);
      @(negedge clk);
      chk({tag, "_done_once"}, 132'(done), 132'd0);
   endtask

   initial begin
      logic [4:0]  a;
      logic [31:0] seen;
      logic [3:0]  h_opc;
      logic [127:0] h_pay;
      logic [4:0]  h_addr;
      logic [4:0]  h_rp;

      for (int i = 0; i < 32; i++) begin
         logic [31:0] pa;
         logic [31:0] pb;
         pa = 32'hF000_0000 | (32'(i) * 32'h0000_0111);
         pb = (32'(i) * 32'h0101_0101) ^ 32'h8000_0000;
         mem[i] = {4'(i * 7 + 1), pa, pb, ~pa, pb ^ 32'h5A5A_5A5A};
      end

      reset = 1'b1; start = 1'b0; order = 4'd0; first_addr = 5'd0; count = 6'd0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {read_pointer, out_valid, out_opc, out_op_a, out_op_b, out_result, out_addr, busy, done},
          '0);
      reset = 1'b0;
      @(negedge clk);

      // INC with wrap
      start_cmd(4'd0, 5'd30, 6'd4);
      chk("inc_busy", 132'(busy), 132'd1);
      expect_word("inc0", 5'd30);
      expect_word("inc1", 5'd31);
      expect_word("inc2", 5'd0);
      expect_word("inc3", 5'd1);
      expect_done("inc");

      // DEC with wrap
      start_cmd(4'd2, 5'd1, 6'd3);
      expect_word("dec0", 5'd1);
      expect_word("dec1", 5'd0);
      expect_word("dec2", 5'd31);
      expect_done("dec");

      // Undefined order code falls back to INC
      start_cmd(4'hF, 5'd31, 6'd2);
      expect_word("ord0", 5'd31);
      expect_word("ord1", 5'd0);
      expect_done("ord");

      // RAND, fixed prefix then full coverage; count 32 and clamped 40
      start_cmd(4'd1, 5'd0, 6'd32);
      expect_word("rnd0", 5'd0);
      expect_word("rnd1", 5'd3);
      expect_word("rnd2", 5'd18);
      expect_word("rnd3", 5'd29);
      expect_word("rnd4", 5'd20);
      a = 5'd20; seen = 32'h2000_0000 | 32'h0004_0000 | 32'h9 | 32'h0010_0000;
      for (int i = 5; i < 32; i++) begin
         a = 5'((32'(a) * 5 + 3) % 32);
         seen[a] = 1'b1;
         expect_word("rnd", a);
      end
      chk("rnd_cover", 132'(seen), 132'hFFFF_FFFF);
      expect_done("rnd32");

      start_cmd(4'd1, 5'd7, 6'd40);
      a = 5'd7; seen = '0;
      for (int i = 0; i < 32; i++) begin
         seen[a] = 1'b1;
         expect_word("clamp", a);
         a = 5'((32'(a) * 5 + 3) % 32);
      end
      chk("clamp_cover", 132'(seen), 132'hFFFF_FFFF);
      expect_done("clamp");

      // Backpressure: word held stable, consumed exactly once
      out_ready = 1'b0;
      start_cmd(4'd0, 5'd5, 6'd2);
      @(negedge clk);
      chk("bp_valid", 132'(out_valid), 132'd1);
      h_opc = out_opc; h_pay = {out_op_a, out_op_b, out_result}; h_addr = out_addr; h_rp = read_pointer;
      chk("bp_first", {h_opc, h_pay}, mem[5]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold", {out_valid, out_opc, out_op_a, out_op_b, out_result, out_addr, read_pointer},
             {1'b1, h_opc, h_pay, h_addr, h_rp});
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_consumed", 132'(out_valid), 132'd0);
      expect_word("bp_next", 5'd6);
      expect_done("bp");

      // Reset after the 2nd handshake aborts without done
      start_cmd(4'd0, 5'd10, 6'd10);
      expect_word("rm0", 5'd10);
      expect_word("rm1", 5'd11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rm_outputs", {read_pointer, out_valid, out_opc, out_op_a, out_op_b, out_result, out_addr, busy, done},
          '0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rm_quiet", {busy, done, out_valid}, '0);
      end
      start_cmd(4'd2, 5'd1, 6'd3);
      expect_word("rs0", 5'd1);
      expect_word("rs1", 5'd0);
      expect_word("rs2", 5'd31);
      expect_done("rs");

      // count 0: straight to done, no data
      start_cmd(4'd0, 5'd3, 6'd0);
      chk("zero_valid", 132'(out_valid), 132'd0);
      expect_done("zero");
      chk("zero_valid_after", 132'(out_valid), 132'd0);

      // start while busy is ignored
      start_cmd(4'd0, 5'd20, 6'd3);
      start_cmd(4'd2, 5'd9, 6'd30);
      expect_word("ign0", 5'd20);
      expect_word("ign1", 5'd21);
      expect_word("ign2", 5'd22);
      expect_done("ign");
      chk("ign_idle", {busy, out_valid}, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
